// File: rtl/conversor_paralelo_serie_pkg.sv
// Shared definitions for the parallel/serial converter pair: FSM encoding and
// the counter width helper.
package conversor_paralelo_serie_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT
  } state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conversor_paralelo_serie.sv
// Parallel-to-serial converter with a one-word holding register so that
// back-to-back words leave q with no idle gap between frames.
module conversor_paralelo_serie
  import conversor_paralelo_serie_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         q,
  output logic         q_valid,
  output logic         sof,
  output logic         eof
);

  localparam int unsigned     CntW    = cnt_width(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    shift_q, shift_d;
  logic [N-1:0]    hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            accept;
  logic            out_bit;
  logic [N-1:0]    shifted;

  assign load_ready = ~hold_full_q;
  assign accept     = load_valid & load_ready;
  assign out_bit    = MSB_FIRST ? shift_q[N-1] : shift_q[0];
  assign shifted    = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = din;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q != CntLast) begin
          shift_d = shifted;
          cnt_d   = cnt_q + 1'b1;
          if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // Held word follows immediately; a same-edge accept would refill hold.
          shift_d     = hold_q;
          cnt_d       = '0;
          hold_full_d = accept;
          if (accept) begin
            hold_d = din;
          end
        end else if (accept) begin
          shift_d = din;
          cnt_d   = '0;
        end else begin
          shift_d = shifted;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

  assign q_valid = (state_q == StShift);
  assign sof     = q_valid && (cnt_q == '0);
  assign eof     = q_valid && (cnt_q == CntLast);
  assign q       = q_valid & out_bit;

endmodule

// File: tb/tb_conversor_paralelo_serie.sv
// Bench for conversor_paralelo_serie: MSB-first and LSB-first instances share
// stimulus and are checked against a bit-queue reference model.
module tb_conversor_paralelo_serie;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic [N-1:0] din = '0;
  logic         load_valid = 1'b0;

  logic rdy_m, q_m, qv_m, sof_m, eof_m;
  logic rdy_l, q_l, qv_l, sof_l, eof_l;
  logic [4:0] obs_m, obs_l;

  assign obs_m = {rdy_m, q_m, qv_m, sof_m, eof_m};
  assign obs_l = {rdy_l, q_l, qv_l, sof_l, eof_l};

  int checks   = 0;
  int failures = 0;

  conversor_paralelo_serie #(.N(N), .MSB_FIRST(1'b1)) dut_m (
    .clk       (clk),
    .clr       (clr),
    .din       (din),
    .load_valid(load_valid),
    .load_ready(rdy_m),
    .q         (q_m),
    .q_valid   (qv_m),
    .sof       (sof_m),
    .eof       (eof_m)
  );

  conversor_paralelo_serie #(.N(N), .MSB_FIRST(1'b0)) dut_l (
    .clk       (clk),
    .clr       (clr),
    .din       (din),
    .load_valid(load_valid),
    .load_ready(rdy_l),
    .q         (q_l),
    .q_valid   (qv_l),
    .sof       (sof_l),
    .eof       (eof_l)
  );

  always #10 clk = ~clk;

  // Reference: queue of every bit not yet sent; front is what q shows now.
  // A word is waiting in hold exactly when more than N bits are outstanding.
  typedef struct packed {
    bit bm;
    bit bl;
    bit s;
    bit e;
  } mbit_t;

  mbit_t mq[$];
  bit    last_acc;

  function automatic logic [4:0] exp_vec(input bit msb);
    if (mq.size() == 0) return 5'b10000;
    return {mq.size() <= N, msb ? mq[0].bm : mq[0].bl, 1'b1, mq[0].s, mq[0].e};
  endfunction

  task automatic step(input logic v, input logic [N-1:0] d);
    bit acc;
    load_valid = v;
    din        = d;
    acc        = v && (mq.size() <= N);
    @(posedge clk);
    if (mq.size() > 0) void'(mq.pop_front());
    if (acc) begin
      for (int i = 0; i < N; i++) begin
        mq.push_back('{bm: d[N-1-i], bl: d[i], s: (i == 0), e: (i == N - 1)});
      end
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    #15;
    checks += 2;
    if (obs_m !== 5'b10000) begin
      failures++; $display("FAIL reset_hold_m got=%b exp=10000", obs_m);
    end
    if (obs_l !== 5'b10000) begin
      failures++; $display("FAIL reset_hold_l got=%b exp=10000", obs_l);
    end
    @(negedge clk);
    clr = 1'b1;
    mq.delete();
    for (int c = 0; c < 3; c++) begin
      step(1'b0, '0);
      checks += 2;
      if (obs_m !== exp_vec(1'b1)) begin
        failures++; $display("FAIL reset_idle_m cyc=%0d got=%b exp=%b", c, obs_m, exp_vec(1'b1));
      end
      if (obs_l !== exp_vec(1'b0)) begin
        failures++; $display("FAIL reset_idle_l cyc=%0d got=%b exp=%b", c, obs_l, exp_vec(1'b0));
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] capm = '0, capl = '0;
    for (int c = 0; c < 6; c++) begin
      step(c == 0, 4'b1011);
      checks += 2;
      if (obs_m !== exp_vec(1'b1)) begin
        failures++; $display("FAIL single_m cyc=%0d got=%b exp=%b", c, obs_m, exp_vec(1'b1));
      end
      if (obs_l !== exp_vec(1'b0)) begin
        failures++; $display("FAIL single_l cyc=%0d got=%b exp=%b", c, obs_l, exp_vec(1'b0));
      end
      if (c < 4) begin
        capm = {capm[2:0], q_m};
        capl = {capl[2:0], q_l};
      end
    end
    checks += 3;
    if (capm !== 4'b1011) begin
      failures++; $display("FAIL single_bits_m got=%b exp=1011", capm);
    end
    if (capl !== 4'b1101) begin
      failures++; $display("FAIL single_bits_l got=%b exp=1101", capl);
    end
    if (qv_m !== 1'b0) begin
      failures++; $display("FAIL single_after got=%b exp=0", qv_m);
    end
  endtask

  task automatic test_stream();
    logic [7:0] capm = '0, capl = '0, qvs = '0;
    int nsof = 0, neof = 0;
    for (int c = 0; c < 10; c++) begin
      step(c < 2, (c == 0) ? 4'hA : 4'h5);
      checks += 2;
      if (obs_m !== exp_vec(1'b1)) begin
        failures++; $display("FAIL stream_m cyc=%0d got=%b exp=%b", c, obs_m, exp_vec(1'b1));
      end
      if (obs_l !== exp_vec(1'b0)) begin
        failures++; $display("FAIL stream_l cyc=%0d got=%b exp=%b", c, obs_l, exp_vec(1'b0));
      end
      if (c < 8) begin
        capm = {capm[6:0], q_m};
        capl = {capl[6:0], q_l};
        qvs  = {qvs[6:0], qv_m};
      end
      nsof += int'(sof_m);
      neof += int'(eof_m);
    end
    checks += 4;
    if (capm !== 8'b10100101) begin
      failures++; $display("FAIL stream_bits_m got=%b exp=10100101", capm);
    end
    if (capl !== 8'b01011010) begin
      failures++; $display("FAIL stream_bits_l got=%b exp=01011010", capl);
    end
    if (qvs !== 8'hFF) begin
      failures++; $display("FAIL stream_gap got=%b exp=11111111", qvs);
    end
    if (nsof != 2 || neof != 2) begin
      failures++; $display("FAIL stream_frames got=sof%0d/eof%0d exp=2/2", nsof, neof);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] w[3];
    logic [11:0] capm = '0;
    int idx = 0, nbits = 0, nsof = 0;
    w[0] = 4'h3; w[1] = 4'hC; w[2] = 4'h9;
    for (int c = 0; c < 30; c++) begin
      step(idx < 3, (idx < 3) ? w[idx] : 4'h0);
      if (last_acc) idx++;
      checks += 2;
      if (obs_m !== exp_vec(1'b1)) begin
        failures++; $display("FAIL bp_m cyc=%0d got=%b exp=%b", c, obs_m, exp_vec(1'b1));
      end
      if (obs_l !== exp_vec(1'b0)) begin
        failures++; $display("FAIL bp_l cyc=%0d got=%b exp=%b", c, obs_l, exp_vec(1'b0));
      end
      if (qv_m) begin
        capm = {capm[10:0], q_m};
        nbits++;
      end
      nsof += int'(sof_m);
    end
    checks += 2;
    if (capm !== 12'b0011_1100_1001 || nbits != 12) begin
      failures++; $display("FAIL bp_bits got=%b/%0d exp=001111001001/12", capm, nbits);
    end
    if (nsof != 3 || idx != 3) begin
      failures++; $display("FAIL bp_words got=sof%0d/acc%0d exp=3/3", nsof, idx);
    end
  endtask

  task automatic test_lsb();
    logic [3:0] capm = '0, capl = '0;
    for (int c = 0; c < 6; c++) begin
      step(c == 0, 4'b0001);
      checks += 2;
      if (obs_m !== exp_vec(1'b1)) begin
        failures++; $display("FAIL lsb_m cyc=%0d got=%b exp=%b", c, obs_m, exp_vec(1'b1));
      end
      if (obs_l !== exp_vec(1'b0)) begin
        failures++; $display("FAIL lsb_l cyc=%0d got=%b exp=%b", c, obs_l, exp_vec(1'b0));
      end
      if (c < 4) begin
        capm = {capm[2:0], q_m};
        capl = {capl[2:0], q_l};
      end
    end
    checks += 2;
    if (capl !== 4'b1000) begin
      failures++; $display("FAIL lsb_bits_l got=%b exp=1000", capl);
    end
    if (capm !== 4'b0001) begin
      failures++; $display("FAIL lsb_bits_m got=%b exp=0001", capm);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] capm = '0, capl = '0;
    step(1'b1, 4'hF);
    step(1'b0, 4'h0);
    checks += 1;
    if (!(qv_m && q_m && !sof_m)) begin
      failures++; $display("FAIL mid_pre got=%b exp=bit2 of frame", obs_m);
    end
    #5;
    clr = 1'b0;
    #1;
    mq.delete();
    checks += 2;
    if (obs_m !== 5'b10000) begin
      failures++; $display("FAIL mid_async_m got=%b exp=10000", obs_m);
    end
    if (obs_l !== 5'b10000) begin
      failures++; $display("FAIL mid_async_l got=%b exp=10000", obs_l);
    end
    @(negedge clk);
    clr = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(c == 0, 4'h8);
      checks += 2;
      if (obs_m !== exp_vec(1'b1)) begin
        failures++; $display("FAIL mid_m cyc=%0d got=%b exp=%b", c, obs_m, exp_vec(1'b1));
      end
      if (obs_l !== exp_vec(1'b0)) begin
        failures++; $display("FAIL mid_l cyc=%0d got=%b exp=%b", c, obs_l, exp_vec(1'b0));
      end
      if (c < 4) begin
        capm = {capm[2:0], q_m};
        capl = {capl[2:0], q_l};
      end
    end
    checks += 2;
    if (capm !== 4'b1000) begin
      failures++; $display("FAIL mid_bits_m got=%b exp=1000", capm);
    end
    if (capl !== 4'b0001) begin
      failures++; $display("FAIL mid_bits_l got=%b exp=0001", capl);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic v;
      v = ((c / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(v, N'($urandom));
      checks += 2;
      if (obs_m !== exp_vec(1'b1)) begin
        failures++; $display("FAIL rand_m cyc=%0d got=%b exp=%b", c, obs_m, exp_vec(1'b1));
      end
      if (obs_l !== exp_vec(1'b0)) begin
        failures++; $display("FAIL rand_l cyc=%0d got=%b exp=%b", c, obs_l, exp_vec(1'b0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_lsb();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
